// File: rtl/spi_subperipheral_pkg.sv
// Shared types and constants for the SPI subperipheral router and its data mux.
package spi_subperipheral_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECTED,
    ST_UNMAPPED
  } spi_subperipheral_state_t;

  localparam logic [7:0] DEFAULT_ADDRESS_BASE  = 8'hDB;
  localparam logic [7:0] DEFAULT_UNMAPPED_DATA = 8'h00;

  // Index width for n channels; never narrower than one bit so n=1 still elaborates.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_subperipheral_data_mux.sv
// Registered N:1 data/valid mux with an index, an enable and a constant-data override.
module spi_subperipheral_data_mux #(
  parameter int NUM_CHANNELS = 2,
  parameter int DATA_WIDTH = 8,
  parameter int INDEX_WIDTH = 1,
  parameter logic [DATA_WIDTH-1:0] OVERRIDE_DATA = '0
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_CHANNELS-1:0]            data_in_valid,
  input  logic [INDEX_WIDTH-1:0]             index,
  input  logic                               enable,
  input  logic                               override,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic                               data_out_valid
);

  // Override wins over the selected channel; an out-of-range index reads as idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else if (override) begin
      data_out       <= OVERRIDE_DATA;
      data_out_valid <= 1'b1;
    end else if (enable && (int'(index) < NUM_CHANNELS)) begin
      data_out       <= data_in[int'(index)*DATA_WIDTH +: DATA_WIDTH];
      data_out_valid <= data_in_valid[index];
    end else begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_subperipheral_router.sv
// Registered router between the SPI register-address decode and N subperipherals:
// latches the address once per transaction, holds one-hot selection, reports unmapped hits.
module spi_subperipheral_router
  import spi_subperipheral_pkg::*;
#(
  parameter int NUM_SUBPERIPHERALS = 2,
  parameter logic [7:0] ADDRESS_BASE = DEFAULT_ADDRESS_BASE,
  parameter int DATA_WIDTH = 8,
  parameter logic [7:0] UNMAPPED_DATA = DEFAULT_UNMAPPED_DATA
) (
  input  logic                                     clock,
  input  logic                                     reset_n,
  input  logic [7:0]                               address_in,
  input  logic                                     address_in_valid,
  input  logic [NUM_SUBPERIPHERALS*DATA_WIDTH-1:0] subperipheral_data_in,
  input  logic [NUM_SUBPERIPHERALS-1:0]            subperipheral_data_in_valid,
  output logic [NUM_SUBPERIPHERALS-1:0]            subperipheral_enable_out,
  output logic [NUM_SUBPERIPHERALS-1:0]            subperipheral_start_out,
  output logic [DATA_WIDTH-1:0]                    peripheral_data_out,
  output logic                                     peripheral_data_out_valid,
  output logic                                     unmapped_access_out,
  output logic [7:0]                               unmapped_count_out
);

  localparam int IDX_W = clog2_min1(NUM_SUBPERIPHERALS);
  localparam int END_INT = int'(ADDRESS_BASE) + NUM_SUBPERIPHERALS;
  localparam logic [8:0] BASE_9 = {1'b0, ADDRESS_BASE};
  localparam logic [8:0] END_9 = 9'(END_INT);
  localparam logic [DATA_WIDTH-1:0] UNMAPPED_EXT = DATA_WIDTH'(UNMAPPED_DATA);

  if (END_INT > 256 || NUM_SUBPERIPHERALS < 1 || NUM_SUBPERIPHERALS > 16) begin : g_bad_params
    $fatal(1, "spi_subperipheral_router: address map exceeds 8 bits or channel count outside 1..16");
  end

  spi_subperipheral_state_t state_q, state_d;
  logic [IDX_W-1:0]              idx;
  logic [IDX_W-1:0]              new_idx;
  logic                          in_range;
  logic                          select_start;
  logic                          unmapped_start;
  logic [NUM_SUBPERIPHERALS-1:0] enable_d;
  logic [NUM_SUBPERIPHERALS-1:0] start_q;
  logic                          unmapped_q;
  logic [7:0]                    count_q;

  assign in_range       = ({1'b0, address_in} >= BASE_9) && ({1'b0, address_in} < END_9);
  assign new_idx        = IDX_W'(address_in - ADDRESS_BASE);
  assign select_start   = (state_q == ST_IDLE) && address_in_valid && in_range;
  assign unmapped_start = (state_q == ST_IDLE) && address_in_valid && !in_range;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    enable_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (address_in_valid) state_d = in_range ? ST_SELECTED : ST_UNMAPPED;
      end
      ST_SELECTED: begin
        enable_d = NUM_SUBPERIPHERALS'(1) << idx;
        if (!address_in_valid) state_d = ST_IDLE;
      end
      ST_UNMAPPED: begin
        if (!address_in_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A single channel needs no index register: the selection is always channel 0.
  if (NUM_SUBPERIPHERALS == 1) begin : g_single
    assign idx = '0;
  end else begin : g_multi
    logic [IDX_W-1:0] idx_q;
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)          idx_q <= '0;
      else if (select_start) idx_q <= new_idx;
    end
    assign idx = idx_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      start_q    <= '0;
      unmapped_q <= 1'b0;
      count_q    <= '0;
    end else begin
      start_q    <= select_start ? (NUM_SUBPERIPHERALS'(1) << new_idx) : '0;
      unmapped_q <= unmapped_start;
      if (unmapped_start && (count_q != 8'hFF)) count_q <= count_q + 8'd1;
    end
  end

  spi_subperipheral_data_mux #(
    .NUM_CHANNELS (NUM_SUBPERIPHERALS),
    .DATA_WIDTH   (DATA_WIDTH),
    .INDEX_WIDTH  (IDX_W),
    .OVERRIDE_DATA(UNMAPPED_EXT)
  ) u_data_mux (
    .clock         (clock),
    .reset_n       (reset_n),
    .data_in       (subperipheral_data_in),
    .data_in_valid (subperipheral_data_in_valid),
    .index         (idx),
    .enable        (state_q == ST_SELECTED),
    .override      (state_q == ST_UNMAPPED),
    .data_out      (peripheral_data_out),
    .data_out_valid(peripheral_data_out_valid)
  );

  assign subperipheral_enable_out = enable_d;
  assign subperipheral_start_out  = start_q;
  assign unmapped_access_out      = unmapped_q;
  assign unmapped_count_out       = count_q;

endmodule
